// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: FSM state type and
// vector-space sizing.
package gate_chk_pkg;

   localparam int NUM_VECTORS = 8;
   localparam int IDX_W       = 3;

   // Index of the final vector in a sweep; reaching it ends the run.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Loadable down-counter that measures how long a stimulus vector has been
// held. tc is high while the count sits at zero.
module settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Load takes priority; otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps all eight {A,B,C} input combinations through an external gate
// network, lets each settle for SETTLE cycles, and compares the S1/S2
// responses against per-vector expected tables. Reports a failure count,
// the first failing index and an overall pass flag.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       A,
   output logic       B,
   output logic       C,
   input  logic       S1,
   input  logic       S2,
   input  logic [7:0] exp_s1,
   input  logic [7:0] exp_s2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] first_fail_idx
);

   if ((SETTLE < 1) || (SETTLE > 15)) begin : g_settle_range
      $error("gate_response_checker: SETTLE must be within 1..15");
   end

   // The timer counts down from SETTLE-1, so WAIT lasts exactly SETTLE cycles.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic             start_run;
   logic             timer_load;
   logic             timer_en;
   logic             check_en;
   logic             settle_tc;
   logic             mismatch;

   settle_timer #(
      .W (4)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .en       (timer_en),
      .tc       (settle_tc)
   );

   // A vector fails if either response bit disagrees with its table entry.
   assign mismatch = (S1 != exp_s1[idx]) || (S2 != exp_s2[idx]);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-state control strobes; start is only honoured when idle or done.
   always_comb begin
      state_nxt  = state;
      start_run  = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      check_en   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_run  = 1'b1;
               timer_load = 1'b1;
               state_nxt  = WAIT;
            end
         end
         WAIT: begin
            timer_en = 1'b1;
            if (settle_tc) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            check_en = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
            end else begin
               timer_load = 1'b1;
               state_nxt  = WAIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Vector index and failure bookkeeping; a new run clears the previous result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx            <= '0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_idx <= '0;
      end else if (start_run) begin
         idx            <= '0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_idx <= '0;
      end else if (check_en) begin
         if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (!fail_valid) begin
               fail_valid     <= 1'b1;
               first_fail_idx <= idx;
            end
         end
         if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Status and stimulus outputs decode directly from the state so they are
   // all zero in IDLE, including the cycle right after reset.
   assign busy      = (state == WAIT) || (state == CHECK);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == 4'd0);
   assign {A, B, C} = busy ? idx : 3'b000;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (SETTLE=2 and SETTLE=1)
// driven by a behavioural gate network with selectable faults. Expected run
// results go into per-instance queues and a negedge monitor checks each one
// when done rises.
module tb_gate_response_checker;

   typedef struct {
      int err;
      int ffi;
      int fv;
      int pass;
      int lat;
      int start_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Instance 0: SETTLE = 2
   logic       start0 = 1'b0;
   logic       A0, B0, C0, S1_0, S2_0;
   logic [7:0] exp_s1_0 = 8'h00, exp_s2_0 = 8'h00;
   logic       busy0, done0, pass0, fv0;
   logic [3:0] err0;
   logic [2:0] ffi0;
   int         mode0 = 0;
   logic [7:0] fmask0 = 8'h00;
   logic       prev0 = 1'b0;
   exp_t       q0[$];

   // Instance 1: SETTLE = 1
   logic       start1 = 1'b0;
   logic       A1, B1, C1, S1_1, S2_1;
   logic [7:0] exp_s1_1 = 8'h00, exp_s2_1 = 8'h00;
   logic       busy1, done1, pass1, fv1;
   logic [3:0] err1;
   logic [2:0] ffi1;
   int         mode1 = 0;
   logic [7:0] fmask1 = 8'h00;
   logic       prev1 = 1'b0;
   exp_t       q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate network under test: S1 = majority, S2 = parity, with fault modes.
   // 0: healthy, 1: S2 stuck at 0, 2: both outputs inverted, 3: S1 flipped per fm.
   function automatic logic [1:0] resp(input int m, input logic [2:0] v, input logic [7:0] fm);
      logic maj;
      logic par;
      maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      par = ^v;
      case (m)
         1:       return {maj, 1'b0};
         2:       return {~maj, ~par};
         3:       return {maj ^ fm[v], par};
         default: return {maj, par};
      endcase
   endfunction

   assign {S1_0, S2_0} = resp(mode0, {A0, B0, C0}, fmask0);
   assign {S1_1, S2_1} = resp(mode1, {A1, B1, C1}, fmask1);

   gate_response_checker #(.SETTLE(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .A(A0), .B(B0), .C(C0), .S1(S1_0), .S2(S2_0),
      .exp_s1(exp_s1_0), .exp_s2(exp_s2_0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .first_fail_idx(ffi0)
   );

   gate_response_checker #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .A(A1), .B(B1), .C(C1), .S1(S1_1), .S2(S2_1),
      .exp_s1(exp_s1_1), .exp_s2(exp_s2_1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .first_fail_idx(ffi1)
   );

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int err, input int ffi, input int fv, input int pass, input int lat);
      exp_t r;
      r = '{err: err, ffi: ffi, fv: fv, pass: pass, lat: lat, start_cyc: 0};
      return r;
   endfunction

   // Reference: apply every vector to the network and tally disagreements.
   function automatic exp_t model(input logic [7:0] e1, input logic [7:0] e2, input int m,
                                  input logic [7:0] fm, input int settle);
      exp_t       r;
      logic [1:0] s;
      r = mk(0, 0, 0, 0, 8 * (settle + 1) + 1);
      for (int i = 0; i < 8; i++) begin
         s = resp(m, 3'(i), fm);
         if ((s[1] != e1[i]) || (s[0] != e2[i])) begin
            if (r.fv == 0) begin
               r.fv  = 1;
               r.ffi = i;
            end
            r.err++;
         end
      end
      r.pass = (r.err == 0) ? 1 : 0;
      return r;
   endfunction

   // Latency counts cycles from the start-sampling edge: the cycle right after it is 1.
   task automatic check_run(input string tag, input exp_t e, input int err, input int ffi,
                            input int fv, input int pass, input int busy, input int abc);
      chk({tag, ".err_count"}, err, e.err);
      chk({tag, ".pass"}, pass, e.pass);
      chk({tag, ".fail_valid"}, fv, e.fv);
      if (e.fv != 0) chk({tag, ".first_fail_idx"}, ffi, e.ffi);
      chk({tag, ".busy_in_done"}, busy, 0);
      chk({tag, ".abc_in_done"}, abc, 0);
      chk({tag, ".done_latency"}, cyc - e.start_cyc + 1, e.lat);
   endtask

   always @(negedge clk) begin
      if (done0 && !prev0) begin
         if (q0.size() == 0) begin
            chk("d0.unexpected_done", 1, 0);
         end else begin
            check_run("d0", q0[0], err0, ffi0, fv0, pass0, busy0, {A0, B0, C0});
            void'(q0.pop_front());
         end
      end
      prev0 <= done0;
   end

   always @(negedge clk) begin
      if (done1 && !prev1) begin
         if (q1.size() == 0) begin
            chk("d1.unexpected_done", 1, 0);
         end else begin
            check_run("d1", q1[0], err1, ffi1, fv1, pass1, busy1, {A1, B1, C1});
            void'(q1.pop_front());
         end
      end
      prev1 <= done1;
   end

   task automatic launch0(input logic [7:0] e1, input logic [7:0] e2, input int m,
                          input logic [7:0] fm, input exp_t e);
      exp_t x;
      x = e;
      @(negedge clk);
      exp_s1_0 = e1; exp_s2_0 = e2; mode0 = m; fmask0 = fm; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      x.start_cyc = cyc;
      q0.push_back(x);
   endtask

   task automatic launch1(input logic [7:0] e1, input logic [7:0] e2, input int m,
                          input logic [7:0] fm, input exp_t e);
      exp_t x;
      x = e;
      @(negedge clk);
      exp_s1_1 = e1; exp_s2_1 = e2; mode1 = m; fmask1 = fm; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      x.start_cyc = cyc;
      q1.push_back(x);
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk((d == 0) ? "d0.run_timeout" : "d1.run_timeout", (d == 0) ? q0.size() : q1.size(), 0);
      if (d == 0) q0.delete(); else q1.delete();
   endtask

   task automatic check_cleared0(input string tag);
      chk({tag, ".busy"}, busy0, 0);
      chk({tag, ".done"}, done0, 0);
      chk({tag, ".pass"}, pass0, 0);
      chk({tag, ".fail_valid"}, fv0, 0);
      chk({tag, ".err_count"}, err0, 0);
      chk({tag, ".first_fail_idx"}, ffi0, 0);
      chk({tag, ".abc"}, {A0, B0, C0}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r1, r2, rf;
      int         m;
      int         n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_cleared0("reset");
      chk("reset.d1_busy", busy1, 0);
      chk("reset.d1_done", done1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_cleared0("idle");

      // Healthy network against its own truth tables
      launch0(8'hE8, 8'h96, 0, 8'h00, mk(0, 0, 0, 1, 25));
      drain(0);

      // S2 stuck at 0: parity-1 vectors 1,2,4,7 fail
      launch0(8'hE8, 8'h96, 1, 8'h00, mk(4, 1, 1, 0, 25));
      drain(0);

      // Start while in DONE clears the previous (failing) result immediately
      launch0(8'hE8, 8'h96, 0, 8'h00, mk(0, 0, 0, 1, 25));
      chk("restart.done", done0, 0);
      chk("restart.err_count", err0, 0);
      chk("restart.fail_valid", fv0, 0);
      chk("restart.pass", pass0, 0);
      chk("restart.busy", busy0, 1);
      drain(0);

      // Start pulses while busy must be ignored
      launch0(8'hE8, 8'h96, 1, 8'h00, mk(4, 1, 1, 0, 25));
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      drain(0);
      repeat (30) @(negedge clk);

      // Randomised tables and fault masks on the SETTLE=2 instance
      for (int k = 0; k < 6; k++) begin
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         rf = 8'($urandom);
         m  = ($urandom_range(0, 1) != 0) ? 3 : 0;
         launch0(r1, r2, m, rf, model(r1, r2, m, rf, 2));
         drain(0);
      end

      // SETTLE=1, every vector mismatching
      launch1(8'hE8, 8'h96, 2, 8'h00, mk(8, 0, 1, 0, 17));
      drain(1);
      for (int k = 0; k < 3; k++) begin
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         rf = 8'($urandom);
         m  = ($urandom_range(0, 1) != 0) ? 3 : 0;
         launch1(r1, r2, m, rf, model(r1, r2, m, rf, 1));
         drain(1);
      end

      // Reset in the middle of vector 4, with start asserted on the same edge
      launch0(8'hE8, 8'h96, 0, 8'h00, mk(0, 0, 0, 1, 25));
      n = 0;
      while ({A0, B0, C0} != 3'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("abort.reach_vector4", {A0, B0, C0}, 4);
      rst_n  = 1'b0;
      start0 = 1'b1;
      @(posedge clk); #1;
      q0.delete();
      check_cleared0("abort");
      @(negedge clk);
      rst_n  = 1'b1;
      start0 = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort.no_done", done0, 0);
      chk("abort.idle_busy", busy0, 0);

      // Fresh run after the abort completes normally
      launch0(8'hE8, 8'h96, 1, 8'h00, mk(4, 1, 1, 0, 25));
      drain(0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
